// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front-end: hps_io joystick bit map
// and the coin slot state encoding.
package arcade_input_pkg;

  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  function automatic int btn_idx(input int k);
    return 4 + k;
  endfunction

  function automatic int start_idx(input int nb);
    return 4 + nb;
  endfunction

  function automatic int coin_idx(input int nb);
    return 5 + nb;
  endfunction

endpackage

// File: rtl/arcade_coin_pulser.sv
// One coin slot: registered coin edge detect, IDLE/PULSE/GAP frame-timed FSM
// and a saturating 2-bit queue of presses that arrive while a pulse is running.
module arcade_coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_FRAMES     = 4,
  parameter int COIN_GAP_FRAMES = 4,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin,
  input  logic tick,
  output logic pulse,
  output logic busy
);

  localparam logic       INACT      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [3:0] PULSE_LOAD = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_LOAD   = 4'(COIN_GAP_FRAMES);

  coin_state_t state_r, state_n_s;
  logic [3:0]  cnt_r, cnt_n_s;
  logic [1:0]  queue_r, queue_n_s;
  logic        coin_r, coin_d_r;
  logic        press_s;

  assign press_s = coin_r & ~coin_d_r;

  // Next-state, frame counter and queue update.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    queue_n_s = queue_r;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          state_n_s = PULSE;
          cnt_n_s   = PULSE_LOAD;
        end else if (queue_r != 2'd0) begin
          state_n_s = PULSE;
          cnt_n_s   = PULSE_LOAD;
          queue_n_s = queue_r - 2'd1;
        end else begin
          state_n_s = IDLE;
        end
      end
      PULSE, GAP: begin
        if (tick) begin
          if (cnt_r <= 4'd1) begin
            state_n_s = (state_r == PULSE) ? GAP : IDLE;
            cnt_n_s   = (state_r == PULSE) ? GAP_LOAD : 4'd0;
          end else begin
            cnt_n_s = cnt_r - 4'd1;
          end
        end else begin
          cnt_n_s = cnt_r;
        end
        // presses beyond three pending are dropped
        if (press_s && (queue_r != 2'd3)) begin
          queue_n_s = queue_r + 2'd1;
        end else begin
          queue_n_s = queue_r;
        end
      end
      default: begin
        state_n_s = IDLE;
        cnt_n_s   = 4'd0;
        queue_n_s = 2'd0;
      end
    endcase
  end

  // Slot state, edge detect and registered pulse/busy outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      queue_r  <= 2'd0;
      coin_r   <= 1'b0;
      coin_d_r <= 1'b0;
      pulse    <= INACT;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= cnt_n_s;
      queue_r  <= queue_n_s;
      coin_r   <= coin;
      coin_d_r <= coin_r;
      pulse    <= (state_r == PULSE) ? ~INACT : INACT;
      busy     <= (state_n_s != IDLE) || (queue_n_s != 2'd0);
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input front-end: maps hps_io joystick words to registered per-player
// direction/button/start lines and frame-timed coin pulses. Optional AUTOFIRE_EN.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_BUTTONS     = 4,
  parameter int COIN_FRAMES     = 4,
  parameter int COIN_GAP_FRAMES = 4,
  parameter int ACTIVE_LOW      = 1
`ifdef AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_FRAMES = 2
`endif
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic                               vblank,
  input  logic                               share,
  input  logic [16*NUM_PLAYERS-1:0]          joystick,
`ifdef AUTOFIRE_EN
  input  logic [NUM_PLAYERS-1:0]             autofire,
`endif
  output logic [4*NUM_PLAYERS-1:0]           dir_out,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
  output logic [NUM_PLAYERS-1:0]             start_out,
  output logic [NUM_PLAYERS-1:0]             coin_out,
  output logic [NUM_PLAYERS-1:0]             busy
);

  localparam int   NP        = NUM_PLAYERS;
  localparam int   NB        = NUM_BUTTONS;
  localparam int   BTN_BASE  = btn_idx(0);
  localparam int   START_BIT = start_idx(NB);
  localparam int   COIN_BIT  = coin_idx(NB);
  localparam logic INACT     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [NB-1:0] BTN0_MASK = NB'(1);

  logic [15:0]      joy_eff_s [NP];
  logic [15:0]      shared_or_s;
  logic [4*NP-1:0]  dir_n_s;
  logic [NB*NP-1:0] btn_n_s;
  logic [NP-1:0]    start_n_s;
  logic             vblank_r, vblank_d_r;
  logic             tick_s;

  assign tick_s = vblank_r & ~vblank_d_r;

  // OR of every joystick word, used by player 0 in shared mode.
  always_comb begin
    shared_or_s = 16'h0000;
    for (int i = 0; i < NP; i++) begin
      shared_or_s = shared_or_s | joystick[16*i +: 16];
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_player
    logic [NB-1:0] btn_raw_s;
    logic          btn0_s;
    logic          unused_hi_s;

    if (p == 0) begin : g_share
      assign joy_eff_s[p] = share ? shared_or_s : joystick[16*p +: 16];
    end else begin : g_own
      assign joy_eff_s[p] = joystick[16*p +: 16];
    end

    assign btn_raw_s     = joy_eff_s[p][BTN_BASE +: NB];
    assign dir_n_s[4*p +: 4] = {joy_eff_s[p][JOY_U], joy_eff_s[p][JOY_D],
                                joy_eff_s[p][JOY_L], joy_eff_s[p][JOY_R]};
    assign start_n_s[p]  = joy_eff_s[p][START_BIT];
    assign unused_hi_s   = ^joy_eff_s[p][15:COIN_BIT+1];
    assign btn_n_s[NB*p +: NB] = (btn_raw_s & ~BTN0_MASK) | ({NB{btn0_s}} & BTN0_MASK);

`ifdef AUTOFIRE_EN
    localparam logic [3:0] AF_LOAD = 4'(AUTOFIRE_FRAMES);
    logic       af_held_s, af_held_r;
    logic       af_on_r, af_on_n_s;
    logic [3:0] af_cnt_r, af_cnt_n_s;

    assign af_held_s = autofire[p] & btn_raw_s[0];
    assign btn0_s    = autofire[p] ? af_on_n_s : btn_raw_s[0];

    // Autofire phase: starts active on the press, toggles every AF_LOAD ticks.
    always_comb begin
      af_on_n_s  = 1'b0;
      af_cnt_n_s = AF_LOAD;
      if (!af_held_s) begin
        af_on_n_s  = 1'b0;
        af_cnt_n_s = AF_LOAD;
      end else if (!af_held_r) begin
        af_on_n_s  = 1'b1;
        af_cnt_n_s = AF_LOAD;
      end else if (tick_s) begin
        if (af_cnt_r <= 4'd1) begin
          af_on_n_s  = ~af_on_r;
          af_cnt_n_s = AF_LOAD;
        end else begin
          af_on_n_s  = af_on_r;
          af_cnt_n_s = af_cnt_r - 4'd1;
        end
      end else begin
        af_on_n_s  = af_on_r;
        af_cnt_n_s = af_cnt_r;
      end
    end

    // Autofire state registers.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        af_held_r <= 1'b0;
        af_on_r   <= 1'b0;
        af_cnt_r  <= 4'd0;
      end else begin
        af_held_r <= af_held_s;
        af_on_r   <= af_on_n_s;
        af_cnt_r  <= af_cnt_n_s;
      end
    end
`else
    assign btn0_s = btn_raw_s[0];
`endif

    arcade_coin_pulser #(
      .COIN_FRAMES    (COIN_FRAMES),
      .COIN_GAP_FRAMES(COIN_GAP_FRAMES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .coin   (joy_eff_s[p][COIN_BIT]),
      .tick   (tick_s),
      .pulse  (coin_out[p]),
      .busy   (busy[p])
    );
  end

  // Frame tick edge detect.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_r   <= 1'b0;
      vblank_d_r <= 1'b0;
    end else begin
      vblank_r   <= vblank;
      vblank_d_r <= vblank_r;
    end
  end

  // Output stage; polarity is applied here.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir_out   <= {(4*NP){INACT}};
      btn_out   <= {(NB*NP){INACT}};
      start_out <= {NP{INACT}};
    end else begin
      dir_out   <= dir_n_s ^ {(4*NP){INACT}};
      btn_out   <= btn_n_s ^ {(NB*NP){INACT}};
      start_out <= start_n_s ^ {NP{INACT}};
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with default parameters (2 players,
// 4 buttons, 4-frame pulse, 4-frame gap, active-low outputs).
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vblank;
  logic        share;
  logic [31:0] joystick;
`ifdef AUTOFIRE_EN
  logic [1:0]  autofire = 2'b00;
`endif
  logic [7:0]  dir_out;
  logic [7:0]  btn_out;
  logic [1:0]  start_out;
  logic [1:0]  coin_out;
  logic [1:0]  busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;
  logic coin_prev = 1'b1;

  typedef struct {
    logic        share;
    logic [31:0] joy;
    logic [7:0]  dir;
    logic [7:0]  btn;
    logic [1:0]  start;
  } vec_t;

  vec_t vecs [7];

  arcade_input_ctrl dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .vblank   (vblank),
    .share    (share),
    .joystick (joystick),
`ifdef AUTOFIRE_EN
    .autofire (autofire),
`endif
    .dir_out  (dir_out),
    .btn_out  (btn_out),
    .start_out(start_out),
    .coin_out (coin_out),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    if (coin_prev && !coin_out[0]) pulse_cnt++;
    coin_prev = coin_out[0];
  endtask

  // one frame: a single vblank rising edge followed by a quiet stretch
  task automatic frame();
    vblank = 1'b1;
    repeat (10) step();
    vblank = 1'b0;
    repeat (40) step();
  endtask

  task automatic coin_press();
    joystick = 32'h0000_0200;
    step();
    step();
    joystick = 32'h0000_0000;
    step();
    step();
  endtask

  initial begin
    vecs[0] = '{share: 1'b0, joy: 32'h0000_0011, dir: 8'hFE, btn: 8'hFE, start: 2'b11};
    vecs[1] = '{share: 1'b0, joy: 32'h0008_0000, dir: 8'h7F, btn: 8'hFF, start: 2'b11};
    vecs[2] = '{share: 1'b1, joy: 32'h0008_0000, dir: 8'h77, btn: 8'hFF, start: 2'b11};
    vecs[3] = '{share: 1'b1, joy: 32'h0100_0020, dir: 8'hFF, btn: 8'hFD, start: 2'b00};
    vecs[4] = '{share: 1'b0, joy: 32'h0100_0020, dir: 8'hFF, btn: 8'hFD, start: 2'b01};
    vecs[5] = '{share: 1'b0, joy: 32'h000F_00F0, dir: 8'h0F, btn: 8'hF0, start: 2'b11};
    vecs[6] = '{share: 1'b0, joy: 32'h0000_0000, dir: 8'hFF, btn: 8'hFF, start: 2'b11};

    // reset with active joystick: outputs must stay inactive
    reset    = 1'b1;
    vblank   = 1'b0;
    share    = 1'b0;
    joystick = 32'h0000_00FF;
    repeat (3) step();
    check("rst_dir", 32'(dir_out), 32'h0000_00FF);
    check("rst_btn", 32'(btn_out), 32'h0000_00FF);
    check("rst_start", 32'(start_out), 32'h3);
    check("rst_coin", 32'(coin_out), 32'h3);
    check("rst_busy", 32'(busy), 32'h0);
    joystick = 32'h0000_0000;
    reset    = 1'b0;
    step();
    check("post_rst_dir", 32'(dir_out), 32'h0000_00FF);
    check("post_rst_btn", 32'(btn_out), 32'h0000_00FF);
    check("post_rst_start", 32'(start_out), 32'h3);
    check("post_rst_coin", 32'(coin_out), 32'h3);
    check("post_rst_busy", 32'(busy), 32'h0);

    // mapping, polarity and share vectors
    for (int i = 0; i < 7; i++) begin
      share    = vecs[i].share;
      joystick = vecs[i].joy;
      step();
      check($sformatf("vec%0d_dir", i), 32'(dir_out), 32'(vecs[i].dir));
      check($sformatf("vec%0d_btn", i), 32'(btn_out), 32'(vecs[i].btn));
      check($sformatf("vec%0d_start", i), 32'(start_out), 32'(vecs[i].start));
    end
    share = 1'b0;

    // one-cycle R + btn0 blip
    joystick = 32'h0000_0011;
    step();
    check("blip_dir", 32'(dir_out[3:0]), 32'hE);
    check("blip_btn0", 32'(btn_out[0]), 32'h0);
    joystick = 32'h0000_0000;
    step();
    check("blip_dir_back", 32'(dir_out[3:0]), 32'hF);
    check("blip_btn0_back", 32'(btn_out[0]), 32'h1);

    // held coin: latency, one pulse of 4 frames, gap of 4 frames, then idle
    joystick = 32'h0000_0200;
    step();
    step();
    check("coin_lat2", 32'(coin_out[0]), 32'h1);
    step();
    check("coin_lat3", 32'(coin_out[0]), 32'h0);
    repeat (7) step();
    check("held_f0_coin", 32'(coin_out), 32'h2);
    check("held_f0_busy", 32'(busy[0]), 32'h1);
    for (int f = 1; f <= 9; f++) begin
      if (f == 3) joystick = 32'h0000_0000;
      frame();
      check($sformatf("held_f%0d_coin", f), 32'(coin_out[0]), (f < 4) ? 32'h0 : 32'h1);
      check($sformatf("held_f%0d_busy", f), 32'(busy[0]), (f < 8) ? 32'h1 : 32'h0);
    end

    // five presses: one starts the pulse, three queue, one is dropped
    pulse_cnt = 0;
    coin_prev = coin_out[0];
    repeat (5) coin_press();
    check("q_f0_coin", 32'(coin_out[0]), 32'h0);
    check("q_f0_busy", 32'(busy[0]), 32'h1);
    for (int f = 1; f < 40; f++) begin
      frame();
      check($sformatf("q_f%0d_coin", f), 32'(coin_out[0]),
            (((f % 8) < 4) && (f < 32)) ? 32'h0 : 32'h1);
      check($sformatf("q_f%0d_busy", f), 32'(busy[0]), (f < 32) ? 32'h1 : 32'h0);
    end
    check("q_pulse_count", 32'(pulse_cnt), 32'd4);

    // reset two ticks into a pulse with two presses queued
    repeat (3) coin_press();
    frame();
    frame();
    check("mid_coin", 32'(coin_out[0]), 32'h0);
    check("mid_busy", 32'(busy[0]), 32'h1);
    reset = 1'b1;
    step();
    check("mid_rst_coin", 32'(coin_out), 32'h3);
    check("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    for (int f = 1; f <= 10; f++) begin
      frame();
      check($sformatf("after_rst_f%0d_coin", f), 32'(coin_out[0]), 32'h1);
      check($sformatf("after_rst_f%0d_busy", f), 32'(busy[0]), 32'h0);
    end

    // slot 1 is independent of slot 0
    joystick = 32'h0200_0000;
    repeat (3) step();
    joystick = 32'h0000_0000;
    check("slot1_coin", 32'(coin_out), 32'h1);
    check("slot1_busy", 32'(busy), 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
